// File: rtl/hex_display_ctrl.sv
// HEX output endpoint: latches CPU writes and scans them onto a multiplexed
// bank of active-low seven-segment digits, double-buffered at frame wraps.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int GUARD      = 16,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  output logic [31:0]           value,
  output logic [NUM_DIGITS-1:0] digit_n,
  output logic [6:0]            seg_n,
  output logic                  frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIGIT0    = NUM_DIGITS'(1);

  logic [31:0]      pending_r;
  logic [31:0]      active_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic             wrap_s;
  logic [3:0]       nib_s;
  logic             upper_nonzero_s;
  logic             blank_s;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      4'hF: hex_to_seg = 7'h0E;
      default: hex_to_seg = 7'h7F;
    endcase
  endfunction

  assign wrap_s = (idx_r == IDX_LAST) && (cnt_r == CNT_LAST);
  assign value  = pending_r;

  // Select the nibble being scanned and decide whether it is a leading zero.
  always_comb begin
    nib_s           = 4'h0;
    upper_nonzero_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_r) begin
        nib_s = active_r[4*i +: 4];
      end else begin
        nib_s = nib_s;
      end
      if ((IDX_W'(i) >= idx_r) && (active_r[4*i +: 4] != 4'h0)) begin
        upper_nonzero_s = 1'b1;
      end else begin
        upper_nonzero_s = upper_nonzero_s;
      end
    end
    if ((BLANK_LZ != 0) && (idx_r != {IDX_W{1'b0}})) begin
      blank_s = ~upper_nonzero_s;
    end else begin
      blank_s = 1'b0;
    end
  end

  // Write capture, frame-wrap buffer swap and scan counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r <= 32'h0000_0000;
      active_r  <= 32'h0000_0000;
      cnt_r     <= {CNT_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
    end else begin
      if (wr_en) begin
        pending_r <= wr_data;
      end else begin
        pending_r <= pending_r;
      end
      // A write landing on the wrap cycle bypasses pending so it is not lost.
      if (wrap_s && wr_en) begin
        active_r <= wr_data;
      end else if (wrap_s) begin
        active_r <= pending_r;
      end else begin
        active_r <= active_r;
      end
      if (cnt_r == CNT_LAST) begin
        cnt_r <= {CNT_W{1'b0}};
        if (idx_r == IDX_LAST) begin
          idx_r <= {IDX_W{1'b0}};
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
        idx_r <= idx_r;
      end
    end
  end

  // Registered display outputs, dark during the guard interval of each slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_n    <= {NUM_DIGITS{1'b1}};
      seg_n      <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap_s;
      if (cnt_r < CNT_GUARD) begin
        digit_n <= {NUM_DIGITS{1'b1}};
        seg_n   <= 7'h7F;
      end else begin
        digit_n <= ~(DIGIT0 << idx_r);
        seg_n   <= blank_s ? 7'h7F : hex_to_seg(nib_s);
      end
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: two instances (blanking off / on)
// share stimulus; a monitor checks every scan cycle and each completed frame.
module tb_hex_display_ctrl;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [31:0]      wr_data;
  logic [1:0][31:0] val;
  logic [1:0][7:0]  dn;
  logic [1:0][6:0]  sg;
  logic [1:0]       fd;

  int n_checks = 0;
  int n_fail   = 0;
  int frames_done = 0;
  int e_next = 0;
  logic rst_at_edge = 1'b0;

  typedef struct packed {
    logic [55:0] lz0;
    logic [55:0] lz1;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(4), .GUARD(1), .BLANK_LZ(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .value(val[0]), .digit_n(dn[0]), .seg_n(sg[0]), .frame_done(fd[0]));

  hex_display_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(4), .GUARD(1), .BLANK_LZ(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .value(val[1]), .digit_n(dn[1]), .seg_n(sg[1]), .frame_done(fd[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected displayed frame: segment code of digit d at bits [7d +: 7].
  function automatic logic [55:0] exp_frame(input logic [31:0] v, input bit blank);
    logic [55:0] f;
    int top;
    top = 0;
    for (int d = 0; d < 8; d++) if (v[4*d +: 4] != 4'h0) top = d;
    for (int d = 0; d < 8; d++) begin
      if (blank && d > top) f[7*d +: 7] = 7'h7F;
      else f[7*d +: 7] = SEG_TBL[v[4*d +: 4]];
    end
    return f;
  endfunction

  task automatic push_frame(input logic [31:0] v);
    exp_t e;
    e.lz0 = exp_frame(v, 1'b0);
    e.lz1 = exp_frame(v, 1'b1);
    exp_q.push_back(e);
  endtask

  task automatic to_edge(input int n);
    repeat (n - e_next) @(posedge clk);
    #1;
    e_next = n;
  endtask

  task automatic wr(input int n, input logic [31:0] d);
    to_edge(n);
    wr_en = 1'b1;
    wr_data = d;
    to_edge(n + 1);
    wr_en = 1'b0;
    chk("value_readback", val[0], d);
    chk("value_readback_lz", val[1], d);
  endtask

  // Reset as seen by the design at the most recent active edge.
  initial begin
    forever begin
      @(posedge clk);
      rst_at_edge = rst_n;
    end
  end

  // Monitor: per-cycle scan timing checks and whole-frame scoreboard compare.
  initial begin
    int cyc;
    logic [1:0][55:0] rec;
    logic [1:0] prev_fd;
    logic [7:0] exp_dn;
    exp_t e;
    cyc = 0;
    rec = '0;
    prev_fd = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_at_edge) begin
        cyc = 0;
        prev_fd = 2'b00;
      end else begin
        for (int u = 0; u < 2; u++) begin
          exp_dn = (cyc % 4 == 0) ? 8'hFF : ~(8'h01 << (cyc / 4));
          chk("digit_n_scan", dn[u], exp_dn);
          chk("digit_n_onehot", ($countones(~dn[u]) <= 1), 1'b1);
          chk("frame_done_timing", fd[u], (cyc == 31));
          chk("frame_done_width", (fd[u] && prev_fd[u]), 1'b0);
          prev_fd[u] = fd[u];
          if (cyc % 4 == 0) chk("guard_seg", sg[u], 7'h7F);
          else if (cyc % 4 == 1) rec[u][7*(cyc/4) +: 7] = sg[u];
          else chk("seg_stable", sg[u], rec[u][7*(cyc/4) +: 7]);
        end
        if (cyc == 31) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_unexpected: got frame %h with no expectation queued", rec[0]);
          end else begin
            e = exp_q.pop_front();
            chk("frame_nolz", rec[0], e.lz0);
            chk("frame_lz", rec[1], e.lz1);
          end
          frames_done++;
        end
        cyc = (cyc + 1) % 32;
      end
    end
  end

  // Stimulus: directed writes placed at known scan positions.
  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("reset_digit_n", dn[u], 8'hFF);
      chk("reset_seg_n", sg[u], 7'h7F);
      chk("reset_frame_done", fd[u], 1'b0);
      chk("reset_value", val[u], 32'h0);
    end
    push_frame(32'h0000_0000);
    push_frame(32'h1234_ABCD);
    push_frame(32'h0000_00F0);
    push_frame(32'h0000_0000);
    push_frame(32'h3333_3333);
    rst_n = 1'b1;
    e_next = 0;

    wr(10, 32'h1234_ABCD);
    wr(45, 32'h0000_00F0);
    wr(71, 32'h0000_0000);
    wr(101, 32'h1111_1111);
    wr(116, 32'h2222_2222);
    wr(127, 32'h3333_3333);

    // Reset while idx=5, cnt=2 in the frame showing 3s.
    to_edge(182);
    rst_n = 1'b0;
    to_edge(183);
    for (int u = 0; u < 2; u++) begin
      chk("midreset_digit_n", dn[u], 8'hFF);
      chk("midreset_seg_n", sg[u], 7'h7F);
      chk("midreset_value", val[u], 32'h0);
      chk("midreset_frame_done", fd[u], 1'b0);
    end
    to_edge(184);
    rst_n = 1'b1;
    e_next = 0;
    push_frame(32'h0000_0000);
    to_edge(2);
    chk("restart_digit0_en", dn[0], 8'hFE);
    chk("restart_digit0_seg", sg[0], 7'h40);
    chk("restart_digit0_seg_lz", sg[1], 7'h40);
    to_edge(36);

    chk("frames_completed", frames_done, 6);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Display-side endpoint of the CPU's HEX output path: captures 32-bit words written by the core's gpio write strobe (csrrw to HEX).
- Drives a time-multiplexed bank of 8 seven-segment digits: one shared active-low segment bus plus active-low digit enables.
- Double-buffered so a digit scan never shows a mix of two written values.
- Optional leading-zero blanking, anti-ghost guard interval, per-frame strobe.

Parameters:
- NUM_DIGITS, 8: digits scanned; digit 0 = nibble [3:0] (least significant).
- SCAN_DIV, 1000: clk cycles per digit slot; must be >= 2.
- GUARD, 16: cycles at the start of each slot with all digits off; must be < SCAN_DIV.
- BLANK_LZ, 1: 1 enables leading-zero blanking.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  write strobe from CPU writeback (gpio_we)
- wr_data  in  32  value to display
- value  out  32  pending (most recently written) value; readback
- digit_n  out  NUM_DIGITS  digit enables, active-low, at most one low
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
- frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset is synchronous, active-low (rst_n), on clock clk. When rst_n=0 at an edge:
  - pending, active, scan counter cnt, digit index idx all set to 0.
  - digit_n = all ones; seg_n = 7'h7F; frame_done = 0; value = 0.
  - Reset mid-frame aborts the scan immediately; no partial state survives.
- Write:
  - wr_en=1 at an edge loads pending <= wr_data.
  - value reflects the write from the next cycle.
  - Multiple writes within one frame: last wins.
- Scan counter:
  - cnt counts 0..SCAN_DIV-1.
  - At cnt = SCAN_DIV-1: cnt <= 0 and idx <= (idx+1) mod NUM_DIGITS.
- Frame wrap (idx = NUM_DIGITS-1 and cnt = SCAN_DIV-1):
  - active <= pending; if wr_en is asserted the same cycle, active <= wr_data (bypass, the write is not lost).
  - frame_done pulses high on the following cycle, for exactly 1 cycle.
- Outputs: all registered. The value at cycle t+1 is a function of cnt/idx/active at cycle t.
  - If cnt < GUARD: digit_n = all ones, seg_n = 7'h7F.
  - Else: digit_n = ~(1 << idx); seg_n = decode(nibble idx of active), unless the digit is blanked.
- Blanking:
  - When BLANK_LZ=1, digit idx > 0 is blanked if nibbles idx..NUM_DIGITS-1 of active are all zero.
  - A blanked digit drives seg_n = 7'h7F but keeps its digit_n enable low.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Decode (hex, active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Timing:
  - Frame period = NUM_DIGITS*SCAN_DIV cycles.
  - Write-to-display latency is at most one frame plus 2 cycles; displayed content changes only at frame wraps.
- Datapath: counters sized to clog2 of their range; no overflow past terminal count.

Test Plan:
- Reset, SCAN_DIV=4, GUARD=1, BLANK_LZ=0, no writes -> after release, each digit slot shows 1 cycle of digit_n=8'hFF then 3 cycles of digit_n low on that digit with seg_n=7'h40; frame_done pulses every 32 cycles.
- wr_data=32'h1234ABCD mid-frame -> value=32'h1234ABCD next cycle; the current frame still shows zeros; the next frame shows digit0 seg_n=7'h21 (d), digit7 seg_n=7'h79 (1).
- BLANK_LZ=1, wr_data=32'h000000F0 -> digit0 seg_n=7'h40, digit1 seg_n=7'h0E, digits 2..7 seg_n=7'h7F with their digit_n enables still pulsing; wr 0 -> only digit0 shows 7'h40.
- Writes 32'h11111111 then 32'h22222222 in one frame, plus wr 32'h33333333 on the exact wrap cycle -> the next frame displays all 3s (7'h30); 1s and 2s are never shown.
- Assert rst_n=0 while idx=5, cnt=2 -> next edge: digit_n=all ones, seg_n=7'h7F, value=0; scan restarts at idx 0 and digit 0 shows 7'h40.
- Throughout every run: at most one digit_n bit is low at any time; frame_done is never high two consecutive cycles.
